// File: rtl/oc8051_pmem_arb.sv
// Program-memory arbiter for the oc8051: grants fetch (3 bytes) or MOVC (1 byte)
// and sequences each access through the internal synchronous ROM or the external bus.
module oc8051_pmem_arb #(
  parameter int unsigned INT_ROM_WID = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ea_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [7:0]  if_data1,
  output logic [7:0]  if_data2,
  output logic [7:0]  if_data3,
  input  logic        mc_req,
  input  logic [15:0] mc_addr,
  output logic        mc_ack,
  output logic [7:0]  mc_data,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  output logic        ext_rd,
  output logic [15:0] ext_addr,
  input  logic [7:0]  ext_data,
  input  logic        ext_ack
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INT_RD  = 3'd1;
  localparam logic [2:0] INT_CAP = 3'd2;
  localparam logic [2:0] EXT_RD  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]    state, state_d;
  logic          prio_if, prio_if_d;
  logic          g_fetch, g_fetch_d;
  logic [IW-1:0] idx, idx_d;

  logic          if_ack_d, mc_ack_d, ext_rd_d;
  logic [DW-1:0] if_data1_d, if_data2_d, if_data3_d, mc_data_d;
  logic [AW-1:0] rom_addr_d, ext_addr_d;

  logic          sel_if_c;
  logic          sel_ext_c;
  logic [AW-1:0] sel_addr_c;
  logic [IW-1:0] last_idx_c;

  // Winner of the current request set and its int/ext routing.
  always_comb begin
    sel_if_c   = if_req && (!mc_req || prio_if);
    sel_addr_c = sel_if_c ? if_addr : mc_addr;
    sel_ext_c  = !ea_n || (sel_addr_c[AW-1:INT_ROM_WID] != '0);
    last_idx_c = g_fetch ? IW'(2) : IW'(0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    prio_if_d  = prio_if;
    g_fetch_d  = g_fetch;
    idx_d      = idx;
    if_ack_d   = 1'b0;
    mc_ack_d   = 1'b0;
    ext_rd_d   = ext_rd;
    if_data1_d = if_data1;
    if_data2_d = if_data2;
    if_data3_d = if_data3;
    mc_data_d  = mc_data;
    rom_addr_d = rom_addr;
    ext_addr_d = ext_addr;

    case (state)
      IDLE: begin
        if (!if_ack && !mc_ack && (if_req || mc_req)) begin
          g_fetch_d = sel_if_c;
          idx_d     = '0;
          // A fetch that lost to MOVC is owed the next conflict; serving it settles the debt.
          if (sel_if_c) begin
            prio_if_d = 1'b0;
          end else if (if_req) begin
            prio_if_d = 1'b1;
          end
          if (sel_ext_c) begin
            ext_rd_d   = 1'b1;
            ext_addr_d = sel_addr_c;
            state_d    = EXT_RD;
          end else begin
            rom_addr_d = sel_addr_c;
            state_d    = INT_RD;
          end
        end
      end

      INT_RD: state_d = INT_CAP;

      INT_CAP: begin
        if (g_fetch) begin
          if_data1_d = rom_data1;
          if_data2_d = rom_data2;
          if_data3_d = rom_data3;
          if_ack_d   = 1'b1;
        end else begin
          mc_data_d  = rom_data1;
          mc_ack_d   = 1'b1;
        end
        state_d = IDLE;
      end

      EXT_RD: begin
        if (ext_ack) begin
          if (g_fetch) begin
            case (idx)
              2'd0:    if_data1_d = ext_data;
              2'd1:    if_data2_d = ext_data;
              default: if_data3_d = ext_data;
            endcase
          end else begin
            mc_data_d = ext_data;
          end
          ext_addr_d = AW'(ext_addr + 16'd1);
          idx_d      = IW'(idx + 2'd1);
          if (idx == last_idx_c) begin
            ext_rd_d = 1'b0;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        if_ack_d = g_fetch;
        mc_ack_d = !g_fetch;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      prio_if  <= 1'b0;
      g_fetch  <= 1'b0;
      idx      <= '0;
      if_ack   <= 1'b0;
      mc_ack   <= 1'b0;
      ext_rd   <= 1'b0;
      if_data1 <= '0;
      if_data2 <= '0;
      if_data3 <= '0;
      mc_data  <= '0;
      rom_addr <= '0;
      ext_addr <= '0;
    end else begin
      state    <= state_d;
      prio_if  <= prio_if_d;
      g_fetch  <= g_fetch_d;
      idx      <= idx_d;
      if_ack   <= if_ack_d;
      mc_ack   <= mc_ack_d;
      ext_rd   <= ext_rd_d;
      if_data1 <= if_data1_d;
      if_data2 <= if_data2_d;
      if_data3 <= if_data3_d;
      mc_data  <= mc_data_d;
      rom_addr <= rom_addr_d;
      ext_addr <= ext_addr_d;
    end
  end

endmodule
